cra_serial_sub: RTL and testbench

CRA_SERIAL_SUB -- requirements
Module: cra_serial_sub

---
 rtl/cra_serial_sub_pkg.sv | 25 ++
 rtl/cra_serial_sub_if.sv | 35 +++
 rtl/cra_serial_sub_slice.sv | 37 +++
 rtl/full_adder.sv | 18 +
 rtl/cra_serial_sub.sv | 138 +++++++++++++
 tb/tb_cra_serial_sub.sv | 255 +++++++++++++++++++++++++
 6 files changed

// File: rtl/cra_serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// cra_serial_sub_pkg
// Shared definitions for the chunk-serial carry-ripple subtractor:
//   - default operand width and chunk width
//   - controller state encoding (IDLE=0, RUN=1, DONE=2)
//   - helper that returns the number of chunks processed per operation
// ---------------------------------------------------------------------------
package cra_serial_sub_pkg;

    localparam int CRA_N_DEFAULT = 16;
    localparam int CRA_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cra_state_e;

    // Guarded so an illegal w of zero still elaborates far enough for the
    // parameter check in the top module to report it.
    function automatic int cra_chunks(input int n, input int w);
        return (w >= 1) ? (n / w) : 1;
    endfunction

endpackage

// File: rtl/cra_serial_sub_if.sv
// ---------------------------------------------------------------------------
// cra_serial_sub_if
// Request/result bundle of the serial subtractor.
//   start : request to subtract (master -> slave)
//   a, b  : minuend / subtrahend, n bits (master -> slave)
//   busy  : operation in progress (slave -> master)
//   done  : one-cycle result strobe (slave -> master)
//   s     : a - b modulo 2^n (slave -> master)
//   cout  : carry out, 1 means no borrow (slave -> master)
// ---------------------------------------------------------------------------
interface cra_serial_sub_if
    import cra_serial_sub_pkg::*;
#(
    parameter int n = CRA_N_DEFAULT
);

    logic         start;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         busy;
    logic         done;
    logic [n-1:0] s;
    logic         cout;

    modport master (
        output start, a, b,
        input  busy, done, s, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, s, cout
    );

endinterface

// File: rtl/cra_serial_sub_slice.sv
// ---------------------------------------------------------------------------
// cra_slice
// w-bit carry-ripple adder built from full_adder cells.
//   x, y : w-bit addends
//   cin  : carry into bit 0
//   sum  : w-bit sum
//   cout : carry out of bit w-1
// ---------------------------------------------------------------------------
module cra_slice
    import cra_serial_sub_pkg::*;
#(
    parameter int w = CRA_W_DEFAULT
) (
    input  logic [w-1:0] x,
    input  logic [w-1:0] y,
    input  logic         cin,
    output logic [w-1:0] sum,
    output logic         cout
);

    logic [w:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < w; i++) begin : g_bit
        full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[w];

endmodule

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/cra_serial_sub.sv
// ---------------------------------------------------------------------------
// cra_serial_sub
// Chunk-serial subtractor: s = a - b modulo 2^n, computed as a + ~b + 1
// with one w-bit carry-ripple slice, w bits per clock, LSB chunk first.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : cra_serial_sub_if.slave (start, a, b in; busy, done, s, cout out)
// Timing: accept edge -> n/w RUN cycles -> one DONE cycle -> IDLE.
// The last RUN edge writes the completed result into s/cout, so s/cout
// keep the previous result for the whole of RUN.
// ---------------------------------------------------------------------------
module cra_serial_sub
    import cra_serial_sub_pkg::*;
#(
    parameter int n = CRA_N_DEFAULT,
    parameter int w = CRA_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    cra_serial_sub_if.slave  bus
);

    localparam int CHUNKS = cra_chunks(n, w);
    localparam int CW     = $clog2(CHUNKS + 1);
    localparam int W_SAFE = (w >= 1) ? w : 1;

    typedef logic [n-1:0]  word_t;
    typedef logic [CW-1:0] cnt_t;

    if (w < 1 || n < 1 || (n % W_SAFE) != 0) begin : g_bad_params
        $error("cra_serial_sub: n must be a nonzero multiple of w and w must be >= 1");
    end

    cra_state_e state_q, state_d;
    word_t      a_q, a_d;
    word_t      b_q, b_d;
    word_t      res_q, res_d;
    logic       carry_q, carry_d;
    cnt_t       cnt_q, cnt_d;
    word_t      s_q, s_d;
    logic       cout_q, cout_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [w-1:0] slice_sum;
    logic         slice_cout;

    // The slice always looks at the low chunk of the operand registers;
    // shifting them right each RUN cycle walks it through the word.
    cra_slice #(
        .w (w)
    ) u_slice (
        .x    (a_q[w-1:0]),
        .y    (b_q[w-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtraction as a + ~b with the +1 seeded as carry-in.
                    a_d     = bus.a;
                    b_d     = ~bus.b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> w;
                b_d     = b_q >> w;
                res_d   = (res_q >> w) | (word_t'(slice_sum) << (n - w));
                carry_d = slice_cout;
                cnt_d   = cnt_q + cnt_t'(1);
                // Final chunk: publish the finished word, including this
                // cycle's slice output, on the same edge.
                if (cnt_q == cnt_t'(CHUNKS - 1)) begin
                    s_d     = res_d;
                    cout_d  = slice_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_cra_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_cra_serial_sub
// Self-checking bench for cra_serial_sub (n=16, w=4): directed scenarios
// with literal expectations plus a randomized run against a behavioural
// model that knows only the arithmetic result and the operation timing.
// ---------------------------------------------------------------------------
module tb_cra_serial_sub;
    import cra_serial_sub_pkg::*;

    localparam int N      = 16;
    localparam int W      = 4;
    localparam int CHUNKS = N / W;

    typedef logic [N-1:0] word_t;

    logic clk = 1'b0;
    logic rst;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;

    cra_serial_sub_if #(.n(N)) bus ();

    cra_serial_sub #(
        .n (N),
        .w (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Behavioural reference: an accepted request produces a - b (mod 2^N)
    // and a >= b after CHUNKS busy cycles, followed by a one-cycle done
    // strobe during which new requests are not taken.
    logic  mBusy = 1'b0;
    logic  mDone = 1'b0;
    logic  mCout = 1'b0;
    word_t mS    = '0;
    word_t pendS = '0;
    logic  pendC = 1'b0;
    int    runLeft  = 0;
    int    accepted = 0;
    logic  checkEn  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mBusy   = 1'b0;
            mDone   = 1'b0;
            mS      = '0;
            mCout   = 1'b0;
            runLeft = 0;
        end else if (mDone) begin
            mDone = 1'b0;
        end else if (runLeft > 0) begin
            runLeft--;
            if (runLeft == 0) begin
                mBusy = 1'b0;
                mDone = 1'b1;
                mS    = pendS;
                mCout = pendC;
            end
        end else if (bus.start) begin
            pendS   = bus.a - bus.b;
            pendC   = (bus.a >= bus.b);
            runLeft = CHUNKS;
            mBusy   = 1'b1;
            accepted++;
        end
    end

    // Every cycle after the initial reset, all outputs must match the model.
    always @(negedge clk) begin
        if (checkEn) begin
            testsRun++;
            if ({bus.busy, bus.done, bus.cout, bus.s} !== {mBusy, mDone, mCout, mS}) begin
                testsFailed++;
                $display("[TB] FAIL cycleCompare cycle=%0d got busy=%b done=%b cout=%b s=%h, required busy=%b done=%b cout=%b s=%h",
                         cycle, bus.busy, bus.done, bus.cout, bus.s, mBusy, mDone, mCout, mS);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s got %0h, required %0h", name, actual, expected);
        end
    endtask

    // One-cycle start pulse; returns at the negedge following the accept edge.
    task automatic applyStimulus(input word_t av, input word_t bv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts edges from the accept edge (counted as 1) to the edge raising done.
    task automatic waitDone(output int lat);
        lat = 1;
        while (bus.done !== 1'b1) begin
            if (lat >= 20) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL doneTimeout got no done after %0d cycles, required done within 20", lat);
                return;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic word_t pickOperand();
        case ($urandom_range(7))
            0:       return '0;
            1:       return '1;
            2:       return word_t'(1);
            default: return word_t'($urandom);
        endcase
    endfunction

    initial begin
        int    lat;
        int    doneSeen;
        int    doneCycles[3];
        int    k;
        int    startAcc;
        int    budget;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) @(negedge clk);
        checkOutput("resetBusy", 32'(bus.busy), 32'h0);
        checkOutput("resetDone", 32'(bus.done), 32'h0);
        checkOutput("resetS",    32'(bus.s),    32'h0);
        checkOutput("resetCout", 32'(bus.cout), 32'h0);
        rst     = 1'b0;
        checkEn = 1'b1;

        // Basic subtraction and latency.
        applyStimulus(16'h1234, 16'h0034);
        waitDone(lat);
        checkOutput("basicLatency", 32'(lat), 32'd5);
        checkOutput("basicS",    32'(bus.s),    32'h1200);
        checkOutput("basicCout", 32'(bus.cout), 32'h1);
        checkOutput("modelPinBasic", 32'(mS), 32'h1200);

        // Borrow.
        applyStimulus(16'h0000, 16'h0001);
        waitDone(lat);
        checkOutput("borrowS",    32'(bus.s),    32'hFFFF);
        checkOutput("borrowCout", 32'(bus.cout), 32'h0);
        checkOutput("modelPinBorrow", 32'(mCout), 32'h0);

        // Carry propagates through every chunk.
        applyStimulus(16'hFFFF, 16'hFFFF);
        waitDone(lat);
        checkOutput("chainLatency", 32'(lat), 32'd5);
        checkOutput("chainS",    32'(bus.s),    32'h0000);
        checkOutput("chainCout", 32'(bus.cout), 32'h1);

        // Start during RUN is ignored; s holds the old result until done.
        applyStimulus(16'h0010, 16'h0001);
        bus.start = 1'b1;
        bus.a     = 16'h0000;
        bus.b     = 16'h0005;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("ignoredHeldS", 32'(bus.s), 32'h0000);
        checkOutput("ignoredBusy",  32'(bus.busy), 32'h1);
        waitDone(lat);
        checkOutput("ignoredS",    32'(bus.s),    32'h000F);
        checkOutput("ignoredCout", 32'(bus.cout), 32'h1);
        doneSeen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneSeen++;
        end
        checkOutput("ignoredSingleDone", 32'(doneSeen), 32'd0);

        // Reset in the third RUN cycle abandons the operation.
        applyStimulus(16'h4321, 16'h1111);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midResetBusy", 32'(bus.busy), 32'h0);
        checkOutput("midResetDone", 32'(bus.done), 32'h0);
        checkOutput("midResetS",    32'(bus.s),    32'h0);
        applyStimulus(16'h0008, 16'h0003);
        waitDone(lat);
        checkOutput("afterResetLatency", 32'(lat), 32'd5);
        checkOutput("afterResetS",    32'(bus.s),    32'h0005);
        checkOutput("afterResetCout", 32'(bus.cout), 32'h1);

        // Continuous start: one result every CHUNKS+2 cycles.
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        k = 0;
        for (int i = 0; i < 40 && k < 3; i++) begin
            bus.a = pickOperand();
            bus.b = pickOperand();
            @(negedge clk);
            if (bus.done === 1'b1) begin
                doneCycles[k] = cycle;
                k++;
            end
        end
        bus.start = 1'b0;
        checkOutput("backToBackCount", 32'(k), 32'd3);
        if (k == 3) begin
            checkOutput("backToBackGap1", 32'(doneCycles[1] - doneCycles[0]), 32'd6);
            checkOutput("backToBackGap2", 32'(doneCycles[2] - doneCycles[1]), 32'd6);
        end

        // Randomized run: operands change every cycle, start mostly high,
        // occasional resets; the compare process checks every cycle.
        startAcc = accepted;
        budget   = 0;
        while ((accepted - startAcc) < 10000 && budget < 75000) begin
            @(negedge clk);
            budget++;
            bus.start = ($urandom_range(15) != 0);
            bus.a     = pickOperand();
            bus.b     = pickOperand();
            rst       = ($urandom_range(999) == 0);
        end
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        if ((accepted - startAcc) < 10000) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL randomBudget got %0d operations, required 10000", accepted - startAcc);
        end
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
